// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard unit for the 5-stage pipeline with variable-latency producers.
// A per-register countdown holds the number of cycles until each pending
// result becomes forwardable. A Decode consumer stalls while its source still
// needs two or more cycles. A 3-deep pipe of in-flight PC writes produces
// fetch stall and flush. Saturating counters record stall and flush cycles.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   ValidD                  Decode holds a real instruction
//   RA1D/RA2D, Use1D/Use2D  Decode source registers and their read enables
//   WA3D, RegWriteD, LatD   Decode destination, write enable, producer latency
//   PCSrcD                  Decode instruction writes the PC
//   BranchTakenE            branch in Execute resolved taken
//   Match_*E_*, RegWrite*   Execute-source matches for forwarding
//   ForwardAE/ForwardBE     operand selects: 10 Memory, 01 Writeback, 00 RF
//   StallF/StallD           hold PC / hold the Fetch/Decode register
//   FlushD/FlushE           clear Fetch/Decode / Decode/Execute registers
//   Busy                    per-register pending-write flags
//   StallCount/FlushCount   saturating event counters
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREGS   = 16,
    parameter int ADDR_W  = 4,
    parameter int MAX_LAT = 4,
    parameter int PC_REG  = 15,
    parameter int CNT_W   = 32,
    localparam int LAT_W  = $clog2(MAX_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidD,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic              Use1D,
    input  logic              Use2D,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic [LAT_W-1:0]  LatD,
    input  logic              PCSrcD,
    input  logic              BranchTakenE,
    input  logic              Match_1E_M,
    input  logic              Match_1E_W,
    input  logic              Match_2E_M,
    input  logic              Match_2E_W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [NREGS-1:0]  Busy,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam int ASPACE = 2 ** ADDR_W;

    logic [LAT_W-1:0]  r_cnt [NREGS];
    logic [2:0]        r_pcw;
    logic [CNT_W-1:0]  r_stall_count;
    logic [CNT_W-1:0]  r_flush_count;

    // Per-address "needs >= 2 more cycles" flags, padded to the full address
    // space so any source address can index it; unused addresses read as 0.
    logic [ASPACE-1:0] w_late;
    logic              w_haz1;
    logic              w_haz2;
    logic              w_ldstall;
    logic              w_issue;
    logic              w_pcpend;
    logic [LAT_W-1:0]  w_lat;

    genvar gi;
    generate
        for (gi = 0; gi < ASPACE; gi++) begin : g_late
            if (gi < NREGS) begin : g_real
                assign w_late[gi] = (r_cnt[gi] > LAT_W'(1));
            end else begin : g_pad
                assign w_late[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_haz1    = Use1D & ValidD & (RA1D != ADDR_W'(PC_REG)) & w_late[RA1D];
    assign w_haz2    = Use2D & ValidD & (RA2D != ADDR_W'(PC_REG)) & w_late[RA2D];
    assign w_ldstall = w_haz1 | w_haz2;
    assign w_issue   = ValidD & ~w_ldstall & ~BranchTakenE;

    // Latency 0 behaves as a single-cycle producer; oversized values clamp.
    always_comb begin
        w_lat = LatD;
        if (LatD == '0) begin
            w_lat = LAT_W'(1);
        end else if (LatD > LAT_W'(MAX_LAT)) begin
            w_lat = LAT_W'(MAX_LAT);
        end
    end

    // Scoreboard: a fresh issue overrides the decrement of the same entry.
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt[gi] <= '0;
                end else if (w_issue & RegWriteD & (WA3D == ADDR_W'(gi))) begin
                    r_cnt[gi] <= w_lat;
                end else if (r_cnt[gi] != '0) begin
                    r_cnt[gi] <= r_cnt[gi] - LAT_W'(1);
                end
            end
            assign Busy[gi] = (r_cnt[gi] != '0);
        end
    endgenerate

    // PC-write pipe; a branch kill is already folded into w_issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcw <= '0;
        end else begin
            r_pcw <= {r_pcw[1:0], w_issue & PCSrcD};
        end
    end

    assign w_pcpend = (ValidD & PCSrcD) | r_pcw[0] | r_pcw[1];
    assign StallF   = w_ldstall | w_pcpend;
    assign StallD   = w_ldstall;
    assign FlushD   = w_pcpend | r_pcw[2] | BranchTakenE;
    assign FlushE   = w_ldstall | BranchTakenE;

    // Forwarding: Memory stage has priority over Writeback.
    always_comb begin
        ForwardAE = 2'b00;
        if (Match_1E_M & RegWriteM) begin
            ForwardAE = 2'b10;
        end else if (Match_1E_W & RegWriteW) begin
            ForwardAE = 2'b01;
        end
        ForwardBE = 2'b00;
        if (Match_2E_M & RegWriteM) begin
            ForwardBE = 2'b10;
        end else if (Match_2E_W & RegWriteW) begin
            ForwardBE = 2'b01;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (StallD && (r_stall_count != {CNT_W{1'b1}})) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (FlushE && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
        end
    end

    assign StallCount = r_stall_count;
    assign FlushCount = r_flush_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NREGS   = 16;
    localparam int ADDR_W  = 4;
    localparam int MAX_LAT = 4;
    localparam int PC_REG  = 15;
    localparam int CNT_W   = 6;   // small so saturation is reached in a short run
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int MAXC    = 4000;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              ValidD, Use1D, Use2D, RegWriteD, PCSrcD, BranchTakenE;
    logic [ADDR_W-1:0] RA1D, RA2D, WA3D;
    logic [LAT_W-1:0]  LatD;
    logic              Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W;
    logic              RegWriteM, RegWriteW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, FlushD, FlushE;
    logic [NREGS-1:0]  Busy;
    logic [CNT_W-1:0]  StallCount, FlushCount;

    hazard_scoreboard #(
        .NREGS(NREGS), .ADDR_W(ADDR_W), .MAX_LAT(MAX_LAT),
        .PC_REG(PC_REG), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .ValidD(ValidD), .RA1D(RA1D), .RA2D(RA2D), .Use1D(Use1D), .Use2D(Use2D),
        .WA3D(WA3D), .RegWriteD(RegWriteD), .LatD(LatD), .PCSrcD(PCSrcD),
        .BranchTakenE(BranchTakenE),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .Busy(Busy), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // Reference model: each register remembers the cycle at which its pending
    // result becomes forwardable; PC writes are remembered by issue cycle.
    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    int     ready_at [NREGS];
    bit     pc_iss [MAXC];
    longint m_stall = 0;
    longint m_flush = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int remaining(input int r);
        return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
    endfunction

    function automatic int clamp_lat(input int l);
        if (l == 0) return 1;
        if (l > MAX_LAT) return MAX_LAT;
        return l;
    endfunction

    // PC write k+1 stages past Decode: issued k+1 cycles ago.
    function automatic bit pc_stage(input int k);
        int idx;
        idx = cyc - 1 - k;
        return (idx >= 0) ? pc_iss[idx] : 1'b0;
    endfunction

    task automatic idle();
        reset = 0; ValidD = 0; Use1D = 0; Use2D = 0; RegWriteD = 0; PCSrcD = 0;
        BranchTakenE = 0; RA1D = '0; RA2D = '0; WA3D = '0; LatD = '0;
        Match_1E_M = 0; Match_1E_W = 0; Match_2E_M = 0; Match_2E_W = 0;
        RegWriteM = 0; RegWriteW = 0;
    endtask

    // Called just after a falling edge with inputs set; checks, then advances.
    task automatic step();
        bit h1, h2, ld, iss, pcpend, e_fe;
        logic [1:0] fa, fb;
        logic [NREGS-1:0] busy;
        #1;
        h1 = Use1D && ValidD && (int'(RA1D) != PC_REG) && remaining(int'(RA1D)) >= 2;
        h2 = Use2D && ValidD && (int'(RA2D) != PC_REG) && remaining(int'(RA2D)) >= 2;
        ld = h1 || h2;
        iss = ValidD && !ld && !BranchTakenE;
        pcpend = (ValidD && PCSrcD) || pc_stage(0) || pc_stage(1);
        e_fe = ld || BranchTakenE;
        fa = (Match_1E_M && RegWriteM) ? 2'b10 : (Match_1E_W && RegWriteW) ? 2'b01 : 2'b00;
        fb = (Match_2E_M && RegWriteM) ? 2'b10 : (Match_2E_W && RegWriteW) ? 2'b01 : 2'b00;
        for (int r = 0; r < NREGS; r++) busy[r] = (remaining(r) != 0);

        check_val("StallF", 64'(StallF), 64'(ld || pcpend));
        check_val("StallD", 64'(StallD), 64'(ld));
        check_val("FlushD", 64'(FlushD), 64'(pcpend || pc_stage(2) || BranchTakenE));
        check_val("FlushE", 64'(FlushE), 64'(e_fe));
        check_val("ForwardAE", 64'(ForwardAE), 64'(fa));
        check_val("ForwardBE", 64'(ForwardBE), 64'(fb));
        check_val("Busy", 64'(Busy), 64'(busy));
        check_val("StallCount", 64'(StallCount), 64'(m_stall));
        check_val("FlushCount", 64'(FlushCount), 64'(m_flush));
        $display("cyc %0d rst=%0b v=%0b ra1=%0d wa=%0d lat=%0d stallD=%0b flushD=%0b flushE=%0b busy=%h",
                 cyc, reset, ValidD, RA1D, WA3D, LatD, StallD, FlushD, FlushE, Busy);

        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
            for (int t = 0; t <= cyc && t < MAXC; t++) pc_iss[t] = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (iss && RegWriteD) ready_at[int'(WA3D)] = cyc + 1 + clamp_lat(int'(LatD));
            if (cyc < MAXC) pc_iss[cyc] = iss && PCSrcD;
            if (ld && m_stall < CNT_MAX) m_stall++;
            if (e_fe && m_flush < CNT_MAX) m_flush++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic issue(input int wa, input int lat);
        idle(); ValidD = 1; RegWriteD = 1; WA3D = ADDR_W'(wa); LatD = LAT_W'(lat);
    endtask

    task automatic consume1(input int ra);
        idle(); ValidD = 1; Use1D = 1; RA1D = ADDR_W'(ra);
    endtask

    initial begin
        for (int r = 0; r < NREGS; r++) ready_at[r] = 0;
        idle();
        reset = 1;
        @(posedge clk);
        @(negedge clk);
        step();                          // reset still asserted, state cleared
        idle(); step();                  // idle after reset: all outputs 0

        // ALU producer then immediate consumer with Memory forwarding
        issue(1, 1); step();
        consume1(1); Match_1E_M = 1; RegWriteM = 1; step();
        // Load producer: one bubble
        issue(2, 2); step();
        consume1(2); step(); step();
        idle(); step();
        // Latency 4: three bubbles
        issue(3, 4); step();
        consume1(3); repeat (4) step();
        // Latency 7 clamps to 4
        issue(6, 7); step();
        consume1(6); repeat (4) step();
        // Latency 0 acts as 1
        issue(7, 0); step();
        consume1(7); step();
        // PC register never stalls; unused operand never stalls
        issue(15, 3); step();
        consume1(15); step();
        issue(8, 4); step();
        idle(); ValidD = 1; Use1D = 0; RA1D = 4'd8; Use2D = 1; RA2D = 4'd9; step();
        // Both Writeback forwarding and M-beats-W priority
        idle(); Match_1E_W = 1; RegWriteW = 1; Match_2E_M = 1; Match_2E_W = 1;
        RegWriteM = 1; step();
        // PC write
        idle(); ValidD = 1; PCSrcD = 1; step();
        idle(); repeat (5) step();
        // Branch kills a load in Decode
        issue(4, 2); BranchTakenE = 1; step();
        idle(); repeat (2) step();
        // Mid-operation reset
        issue(5, 3); step();
        idle(); ValidD = 1; PCSrcD = 1; step();
        idle(); reset = 1; step();
        idle(); repeat (3) step();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            idle();
            reset        = ($urandom_range(0, 399) == 0);
            ValidD       = ($urandom_range(0, 9) < 8);
            Use1D        = $urandom_range(0, 1);
            Use2D        = $urandom_range(0, 1);
            RA1D         = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom_range(0, 5));
            RA2D         = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom_range(0, 5));
            WA3D         = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom_range(0, 5));
            RegWriteD    = ($urandom_range(0, 3) != 0);
            LatD         = LAT_W'($urandom_range(0, 7));
            PCSrcD       = ($urandom_range(0, 11) == 0);
            BranchTakenE = ($urandom_range(0, 9) == 0);
            Match_1E_M   = $urandom_range(0, 1);
            Match_1E_W   = $urandom_range(0, 1);
            Match_2E_M   = $urandom_range(0, 1);
            Match_2E_W   = $urandom_range(0, 1);
            RegWriteM    = $urandom_range(0, 1);
            RegWriteW    = $urandom_range(0, 1);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the pipelined core's fixed-latency hazard unit. Sits beside the datapath and controller of the 5-stage pipeline. A per-register pending-write scoreboard detects RAW hazards for producers of any latency up to MAX_LAT, not only loads. A 3-deep in-flight PC-write pipe generates fetch stall and flush. The block also keeps saturating stall and flush event counters for performance measurement.

Parameters:
NREGS, 16, number of architectural registers tracked
ADDR_W, 4, register address width; NREGS <= 2**ADDR_W
MAX_LAT, 4, maximum producer latency, in cycles from issue until the result is forwardable
PC_REG, 15, register index whose reads never stall
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
ValidD  in  1  Decode stage holds a real instruction
RA1D  in  ADDR_W  source register 1 in Decode
RA2D  in  ADDR_W  source register 2 in Decode
Use1D  in  1  RA1D is actually read
Use2D  in  1  RA2D is actually read
WA3D  in  ADDR_W  destination register of the Decode instruction
RegWriteD  in  1  Decode instruction writes WA3D
LatD  in  clog2(MAX_LAT+1)  producer latency of the Decode instruction; 0 is treated as 1, values above MAX_LAT clamp to MAX_LAT
PCSrcD  in  1  Decode instruction writes PC
BranchTakenE  in  1  branch in Execute resolved taken
Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W  in  1 each  Execute-source vs Memory/Writeback destination matches
RegWriteM  in  1  Memory-stage write enable
RegWriteW  in  1  Writeback-stage write enable
ForwardAE  out  2  operand A select: 2'b10 from Memory, 2'b01 from Writeback, 2'b00 from register file
ForwardBE  out  2  operand B select, same encoding as ForwardAE
StallF  out  1  hold PC
StallD  out  1  hold the Fetch/Decode register
FlushD  out  1  clear the Fetch/Decode register
FlushE  out  1  clear the Decode/Execute register
Busy  out  NREGS  bit r set when cnt[r] != 0
StallCount  out  CNT_W  cycles with StallD=1, saturating
FlushCount  out  CNT_W  cycles with FlushE=1, saturating

Behaviour:
- State:
  - cnt[r] for r in 0..NREGS-1, width clog2(MAX_LAT+1)
  - pcw[2:0], in-flight PC writes at stages E, M, W
  - StallCount and FlushCount
- Reset, synchronous: all cnt=0, pcw=0, both perf counters=0. With that state and idle inputs, every output is 0.
- Hazard, combinational:
  - haz1 = Use1D & ValidD & (RA1D != PC_REG) & (cnt[RA1D] >= 2)
  - haz2 is the same expression on RA2D/Use2D
  - ldstall = haz1 | haz2
- Issue: issue = ValidD & ~ldstall & ~BranchTakenE.
- Scoreboard update, each cycle:
  - every nonzero cnt decrements by 1
  - then, if issue & RegWriteD, cnt[WA3D] <= clamp(LatD); the new value overrides the decrement for that entry, including a re-issue to an already-pending register
  - latency 1 (ALU) never stalls a consumer; latency 2 (load) gives exactly one bubble; latency L gives L-1 bubbles
- PC pipe, each cycle: pcw <= {pcw[1:0], issue & PCSrcD}. On BranchTakenE, pcw[0] is written 0 (the Decode instruction is killed); pcw[2:1] are unaffected.
- Outputs:
  - pcpend = (ValidD & PCSrcD) | pcw[0] | pcw[1]
  - StallF = ldstall | pcpend
  - StallD = ldstall
  - FlushD = pcpend | pcw[2] | BranchTakenE
  - FlushE = ldstall | BranchTakenE
- Forwarding, combinational:
  - ForwardAE = 2'b10 if Match_1E_M & RegWriteM
  - else 2'b01 if Match_1E_W & RegWriteW
  - else 2'b00
  - ForwardBE follows the same priority using the Match_2E_* inputs; Memory beats Writeback when both match
- Performance counters: increment when StallD (respectively FlushE) is 1; they hold at 2**CNT_W-1 and do not wrap.
- Simultaneous ldstall and BranchTakenE: FlushE=1, no issue, the scoreboard only decrements.
- Reset asserted mid-operation clears all pending entries and PC writes in the same edge.

Test Plan:
- Issue ADD R1 (LatD=1), then SUB using R1 in the next cycle -> StallD=0 throughout; ForwardAE=10 when Match_1E_M=RegWriteM=1.
- Issue LDR R2 (LatD=2), then consumer of R2 -> StallD=StallF=FlushE=1 for exactly 1 cycle; cnt[R2] sequence 2,1,0; StallCount=1.
- Issue R3 with LatD=4, then consumer -> 3 stall cycles; Busy[3] high for 4 cycles; LatD=7 clamps to 4.
- Consumer reads R15 while cnt[15]=3 -> no stall; consumer with Use1D=0 on a busy register -> no stall.
- Issue PC-writing instruction -> StallF=1 for the D, E and M cycles (3 cycles), FlushD=1 for 4 cycles (D, E, M, W), then both return to 0.
- BranchTakenE=1 while Decode holds LDR R4 -> FlushD=FlushE=1, cnt[4] stays 0. Reset with cnt[5]=3 -> all Busy=0 after 1 edge.
